// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: state encodings, count width helper and parity function shared with the transmitter
package serial_parity_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam int DEF_DATA_W = 8;

    function automatic int count_width(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

    localparam int DEF_CNT_W = count_width(DEF_DATA_W);

    // Parity bit a transmitter appends so the frame satisfies even (odd=0) or odd (odd=1) parity
    function automatic logic parity_of(input logic [63:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// parity_acc: 1-bit running XOR accumulator with clear and enable
module parity_acc (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic din,
    output logic acc
);

    logic acc_q, acc_d;

    // clear wins over accumulate
    always_comb begin
        acc_d = clear ? 1'b0 : (en ? acc_q ^ din : acc_q);
    end

    // accumulator register
    always_ff @(posedge clk) begin
        if (reset) acc_q <= 1'b0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start/data/parity/stop deframer with parity check and a one-word valid/ready output slot
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = count_width(DATA_W);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              acc_clr, acc_en, acc;

    parity_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clr),
        .en    (acc_en),
        .din   (sin),
        .acc   (acc)
    );

    // deframing FSM and output slot; nothing but the handshake moves without bit_en
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q & ~dout_ready;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shreg_d = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d = {sin, shreg_q[DATA_W-1:1]};
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(DATA_W - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    perr_d  = acc ^ sin ^ ODD_PARITY;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!dout_valid_q || dout_ready) begin
                        dout_d       = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ~sin;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: directed test-plan frames plus random frames checked against a word-level model
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_en = 1'b0;
    logic       sin = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout_e, dout_o;
    logic       valid_e, valid_o, pe_e, pe_o, fe_e, fe_o, ovr_e, ovr_o, busy_e, busy_o;

    int checks = 0;
    int errors = 0;

    logic       exp_valid = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_pe = 1'b0;
    logic       exp_pe_odd = 1'b0;
    logic       exp_fe = 1'b0;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .reset(reset), .bit_en(bit_en), .sin(sin),
        .dout(dout_e), .dout_valid(valid_e), .dout_ready(dout_ready),
        .parity_err(pe_e), .frame_err(fe_e), .overrun(ovr_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .reset(reset), .bit_en(bit_en), .sin(sin),
        .dout(dout_o), .dout_valid(valid_o), .dout_ready(dout_ready),
        .parity_err(pe_o), .frame_err(fe_o), .overrun(ovr_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // gap idle cycles with a random line, then one strobe; rdy is asserted only on the strobe cycle
    task automatic send_bit(input logic b, input int gap, input logic rdy);
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            sin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        sin = b;
        dout_ready = rdy;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        dout_ready = 1'b0;
        sin = 1'b1;
    endtask

    task automatic check_slot(input string tag, input logic exp_ovr);
        chk({tag, "_valid"}, valid_e, exp_valid);
        chk({tag, "_valid_odd"}, valid_o, exp_valid);
        if (exp_valid) begin
            chk({tag, "_dout"}, dout_e, exp_dout);
            chk({tag, "_perr"}, pe_e, exp_pe);
            chk({tag, "_perr_odd"}, pe_o, exp_pe_odd);
            chk({tag, "_ferr"}, fe_e, exp_fe);
        end
        chk({tag, "_overrun"}, ovr_e, exp_ovr);
        chk({tag, "_busy"}, busy_e, 1'b0);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                              input logic rdy, input int gap);
        logic ovr;
        logic ones_odd;
        send_bit(1'b0, gap, 1'b0);
        chk({tag, "_start_busy"}, busy_e, 1'b1);
        chk({tag, "_start_ovr"}, ovr_e, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b0);
        send_bit(p, gap, 1'b0);
        chk({tag, "_par_busy"}, busy_e, 1'b1);
        send_bit(s, gap, rdy);
        ovr = exp_valid && !rdy;
        if (!ovr) begin
            ones_odd   = (($countones(d) + int'(p)) % 2) == 1;
            exp_valid  = 1'b1;
            exp_dout   = d;
            exp_pe     = ones_odd;
            exp_pe_odd = !ones_odd;
            exp_fe     = !s;
        end
        check_slot(tag, ovr);
    endtask

    task automatic consume();
        bit_en = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        exp_valid = 1'b0;
        chk("consume_valid", valid_e, 1'b0);
    endtask

    function automatic logic even_bit(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", valid_e, 1'b0);
        chk("rst_dout", dout_e, 8'h00);
        chk("rst_perr", pe_e, 1'b0);
        chk("rst_ferr", fe_e, 1'b0);
        chk("rst_ovr", ovr_e, 1'b0);
        chk("rst_busy", busy_e, 1'b0);

        send_frame("valid_a5", 8'hA5, 1'b0, 1'b1, 1'b0, 0);
        consume();
        send_frame("perr_3c", 8'h3C, 1'b1, 1'b1, 1'b0, 0);
        consume();
        send_frame("ferr_81", 8'h81, even_bit(8'h81), 1'b0, 1'b0, 0);
        consume();

        send_frame("ovr_11", 8'h11, even_bit(8'h11), 1'b1, 1'b0, 0);
        send_frame("ovr_22", 8'h22, even_bit(8'h22), 1'b1, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("ovr_one_pulse", ovr_e, 1'b0);
        consume();
        send_frame("rdy_11", 8'h11, even_bit(8'h11), 1'b1, 1'b0, 0);
        send_frame("rdy_22", 8'h22, even_bit(8'h22), 1'b1, 1'b1, 0);

        send_bit(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_valid = 1'b0;
        chk("midrst_valid", valid_e, 1'b0);
        chk("midrst_dout", dout_e, 8'h00);
        chk("midrst_perr", pe_e, 1'b0);
        chk("midrst_ferr", fe_e, 1'b0);
        chk("midrst_ovr", ovr_e, 1'b0);
        chk("midrst_busy", busy_e, 1'b0);
        send_frame("after_rst_5a", 8'h5A, even_bit(8'h5A), 1'b1, 1'b0, 0);
        consume();

        send_frame("sparse_c3", 8'hC3, even_bit(8'hC3), 1'b1, 1'b0, 3);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       p;
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? !even_bit(d) : even_bit(d);
            if ($urandom_range(0, 2) == 0) consume();
            send_frame("rand", d, p, ($urandom_range(0, 4) != 0), 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial receiver that deframes start/data/parity/stop bit streams, checks parity with a running XOR accumulator, and presents each received word on a valid/ready output port. It is the receiving end of the team's parity-encoding serial transmitter. It sits between a bit-rate strobe generator, which supplies `bit_en`, and any word-wide consumer.

## Interface
- `DATA_W`, default 8: data bits per frame (≥2).
- `ODD_PARITY`, default 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bit_en`  in  1  bit strobe; `sin` is sampled only on cycles where `bit_en`=1.
- `sin`  in  1  serial line; idle high.
- `dout`  out  DATA_W  received word, LSB first on the line.
- `dout_valid`  out  1  word available.
- `dout_ready`  in  1  consumer accepts the word.
- `parity_err`  out  1  parity mismatch for the word held on `dout`; qualified by `dout_valid`.
- `frame_err`  out  1  stop bit was 0 for the word held on `dout`; qualified by `dout_valid`.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy`  out  1  FSM is not IDLE.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE, `bit_en` & `sin`=0 (start bit): clear the shift register, the bit count and the parity accumulator; go to DATA. If `sin`=1, stay in IDLE.
- DATA, on each `bit_en`:
  - shift `sin` in at the MSB and shift right, so the first bit received ends up in `dout[0]`;
  - accumulator ^= `sin`; count++;
  - when count reaches DATA_W-1 while taking a bit, go to PARITY.
- PARITY, on `bit_en`: latch `perr` = accumulator ^ `sin` ^ `ODD_PARITY`; go to STOP.
- STOP, on `bit_en`: `ferr` = ~`sin`; deliver the word; go to IDLE. The word is delivered even when `ferr`=1.
- Delivery:
  - If the output slot is empty, or `dout_ready`=1 in the same cycle, load `dout`, `parity_err`, `frame_err` and set `dout_valid`.
  - Otherwise drop the new word, keep the held word, and pulse `overrun`.
- Handshake:
  - `dout_valid` clears on the edge where `dout_valid` & `dout_ready`, unless a new word loads on that same edge.
  - `dout`, `parity_err` and `frame_err` are stable while `dout_valid`=1 and `dout_ready`=0.
- Cycles with `bit_en`=0 never change the FSM state, the count or the accumulator.
- Reset values:
  - FSM IDLE, count 0, accumulator 0;
  - `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Reset mid-frame discards the partial frame and any held word. There is no `overrun` pulse on reset.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Latency: `dout_valid` goes high on the clock edge that samples the stop bit (`bit_en`=1 in STOP), and is visible in the following cycle.
- A frame takes DATA_W+3 `bit_en` strobes: start, data, parity, stop.
- `overrun` is high for exactly one cycle, aligned with the dropped stop-bit edge.
- `busy` rises on the edge that accepts the start bit and falls on the edge that accepts the stop bit.
- Back-to-back frames: a new start bit is accepted on the very next `bit_en` after the stop bit.
- `bit_en` held constantly at 1 is legal, giving one bit per clock.

## Structure
- Package `serial_parity_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - a bit-count width constant, $clog2(DATA_W);
  - a `parity_of(word, odd)` function, shared with the transmitter.
- Sub-module `parity_acc`: a 1-bit running-XOR accumulator with `clear` and `en` inputs and the same clock/reset. It is instantiated once.
- The FSM, shift register and output slot stay in the top module.

## Test plan
- Valid frame: DATA_W=8, even parity, `bit_en`=1. Send start 0, data 0xA5 LSB first, parity 0, stop 1 → `dout`=0xA5, `dout_valid`=1 one cycle after the stop edge, `parity_err`=0, `frame_err`=0.
- Parity error: send 0x3C with parity bit 1 → `dout`=0x3C, `parity_err`=1, `frame_err`=0. With `ODD_PARITY`=1, the same frame → `parity_err`=0.
- Framing error: send 0x81, correct parity, stop bit 0 → `dout`=0x81, `frame_err`=1, `dout_valid`=1.
- Overrun: hold `dout_ready`=0 and send 0x11 then 0x22 → `dout` stays 0x11 and `overrun` pulses once. Repeat with `dout_ready`=1 on the second stop edge → `dout`=0x22 and no `overrun`.
- Reset mid-frame: assert `reset` after 4 data bits of 0xFF → all outputs 0 and `busy`=0. A following clean frame 0x5A is received correctly.
- Sparse strobe: `bit_en` high 1 cycle in 4, with `sin` toggling on idle cycles → 0xC3 is received correctly, and the idle-cycle toggles have no effect.
